acs_node: RTL and testbench
===========================

# acs_node

Add-compare-select node for the hard-decision rate-1/2 Viterbi decoder. It sits directly downstream of the branch-metric units. It accepts the two 2-bit branch metrics and the two predecessor path metrics for one trellis state, and produces the state's new path metric and survivor decision bit each valid step. It keeps the state's path-metric register, a survivor-decision history for the traceback unit, and a step counter that gates traceback start.

## Interface
- PM_W, 8, path-metric width in bits (>= 6)
- TB_DEPTH, 32, decision-history length and traceback-ready threshold (2..64)
- INIT_ZERO, 0, 1 = this node is trellis state 0 (start metric 0); 0 = start metric INIT_BIAS
- INIT_BIAS, 32, start metric for non-zero states
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- frame_start  input  1  single-cycle pulse that re-initialises the node for a new frame
- in_valid  input  1  branch and path metrics valid this cycle
- bm_a  input  2  branch metric on the edge from predecessor A (path_0 side)
- bm_b  input  2  branch metric on the edge from predecessor B (path_1 side)
- pm_a  input  PM_W  path metric of predecessor A
- pm_b  input  PM_W  path metric of predecessor B
- pm_out  output  PM_W  registered path metric of this state
- dec_bit  output  1  survivor decision: 0 = A chosen, 1 = B chosen
- out_valid  output  1  pm_out/dec_bit updated this cycle
- dec_hist  output  TB_DEPTH  decision history; bit 0 = newest
- tb_ready  output  1  at least TB_DEPTH steps accumulated since frame start

## Operation
- Candidates: cand_a = pm_a + bm_a, cand_b = pm_b + bm_b (bm zero-extended to PM_W). The add behaviour is set by the configuration macro.
- Select: B is taken only if cand_b is strictly smaller. Ties take A and set dec_bit = 0.
- On in_valid, with frame_start low:
  - pm_out <= selected candidate
  - dec_bit <= decision
  - dec_hist <= {dec_hist[TB_DEPTH-2:0], decision}
  - step_cnt increments
  - out_valid <= 1
- Without in_valid: out_valid <= 0, and pm_out, dec_bit and dec_hist hold.
- frame_start (priority over in_valid; same-cycle input is dropped):
  - pm_out <= (INIT_ZERO ? 0 : INIT_BIAS)
  - dec_bit, dec_hist, step_cnt cleared
  - out_valid <= 0
- step_cnt: 7-bit counter, saturating at 127.
- tb_ready = (step_cnt >= TB_DEPTH), registered; it is equivalent to the counter compare and asserts in the same cycle as the TB_DEPTH-th out_valid.
- No backpressure: the node accepts a step every cycle in_valid is high.

## Timing
- Latency: 1 cycle from in_valid to out_valid/pm_out/dec_bit.
- Throughput: 1 step per cycle.
- Reset values (rst_n low at a rising edge):
  - pm_out = INIT_ZERO ? 0 : INIT_BIAS
  - dec_bit = 0, out_valid = 0, dec_hist = 0, tb_ready = 0, step_cnt = 0
- Reset mid-frame discards all state immediately. The first in_valid after reset updates normally, with no frame_start required.
- pm_a/pm_b are sampled in the same cycle as in_valid. In the full trellis they are the previous-cycle pm_out of neighbouring nodes.
- frame_start and rst_n asserted together: reset values result, which are identical.

## Configuration
- ACS_MODULO_NORM_EN defined:
  - Adds wrap modulo 2^PM_W.
  - Compare uses the MSB of (cand_a - cand_b) mod 2^PM_W: MSB = 1 means a < b; zero difference is a tie, taking A.
  - Correct as long as the metric spread is < 2^(PM_W-1), which holds for K=7 hard decision with PM_W=8.
  - Unbounded frame length.
- ACS_MODULO_NORM_EN undefined:
  - Adds saturate at 2^PM_W-1.
  - Unsigned compare.
  - Frame length must stay below the saturation point; a saturated tie selects A.

## Test plan
- Reset, INIT_ZERO=1 -> pm_out=0, out_valid=0, dec_hist=0, tb_ready=0; with INIT_ZERO=0 -> pm_out=32.
- pm_a=10, bm_a=2, pm_b=9, bm_b=0, in_valid one cycle -> next cycle pm_out=9, dec_bit=1, out_valid=1, dec_hist[0]=1.
- Tie: pm_a=5, bm_a=1, pm_b=4, bm_b=2 -> pm_out=6, dec_bit=0.
- Wrap-around, PM_W=8: pm_a=254, bm_a=2, pm_b=3, bm_b=0.
  - With ACS_MODULO_NORM_EN: pm_out=0, dec_bit=0.
  - Without it: pm_out=3, dec_bit=1.
- 32 consecutive in_valid with alternating decisions -> tb_ready rises with the 32nd out_valid and dec_hist=32'hAAAAAAAA or 32'h55555555 per start phase. A frame_start then clears tb_ready and dec_hist and reloads the init metric.
- frame_start and in_valid in the same cycle -> input ignored, pm_out=init value, out_valid=0 next cycle.

Source files
------------

// File: rtl/acs_node_if.sv
// Port bundle for one add-compare-select node: branch/path metrics in,
// updated path metric, survivor decision and decision history out.
interface acs_node_if #(
  parameter int unsigned PM_W     = 8,
  parameter int unsigned TB_DEPTH = 32
);
  logic                frame_start;
  logic                in_valid;
  logic [1:0]          bm_a;
  logic [1:0]          bm_b;
  logic [PM_W-1:0]     pm_a;
  logic [PM_W-1:0]     pm_b;
  logic [PM_W-1:0]     pm_out;
  logic                dec_bit;
  logic                out_valid;
  logic [TB_DEPTH-1:0] dec_hist;
  logic                tb_ready;

  modport master (
    output frame_start, in_valid, bm_a, bm_b, pm_a, pm_b,
    input  pm_out, dec_bit, out_valid, dec_hist, tb_ready
  );

  modport slave (
    input  frame_start, in_valid, bm_a, bm_b, pm_a, pm_b,
    output pm_out, dec_bit, out_valid, dec_hist, tb_ready
  );
endinterface

// File: rtl/acs_node.sv
// Add-compare-select node for a hard-decision rate-1/2 Viterbi decoder.
// Define ACS_MODULO_NORM_EN for wrapping adds with modulo compare; default saturates.
module acs_node #(
  parameter int unsigned PM_W      = 8,
  parameter int unsigned TB_DEPTH  = 32,
  parameter int unsigned INIT_ZERO = 0,
  parameter int unsigned INIT_BIAS = 32
) (
  input logic       clk,
  input logic       rst_n,
  acs_node_if.slave bus
);
  localparam logic [6:0]      CNT_MAX = 7'd127;
  localparam logic [6:0]      TB_THR  = 7'(TB_DEPTH);
  localparam logic [PM_W-1:0] PM_INIT = (INIT_ZERO != 0) ? '0 : PM_W'(INIT_BIAS);

  logic [PM_W-1:0]     cand_a_c;
  logic [PM_W-1:0]     cand_b_c;
  logic [PM_W-1:0]     sel_pm_c;
  logic                sel_b_c;
  logic [6:0]          step_cnt_nxt_c;

  logic [PM_W-1:0]     pm_q;
  logic                dec_q;
  logic                valid_q;
  logic [TB_DEPTH-1:0] hist_q;
  logic                ready_q;
  logic [6:0]          step_cnt;

`ifdef ACS_MODULO_NORM_EN
  logic [PM_W-1:0] diff_c;

  // Wrapping adds; sign of the modular difference orders the candidates.
  always_comb begin
    cand_a_c = bus.pm_a + PM_W'(bus.bm_a);
    cand_b_c = bus.pm_b + PM_W'(bus.bm_b);
    diff_c   = cand_a_c - cand_b_c;
    sel_b_c  = (diff_c != '0) && !diff_c[PM_W-1];
  end
`else
  localparam int unsigned SUM_W = PM_W + 1;
  logic [SUM_W-1:0] sum_a_c;
  logic [SUM_W-1:0] sum_b_c;

  // Saturating adds with plain unsigned compare.
  always_comb begin
    sum_a_c  = SUM_W'(bus.pm_a) + SUM_W'(bus.bm_a);
    sum_b_c  = SUM_W'(bus.pm_b) + SUM_W'(bus.bm_b);
    cand_a_c = sum_a_c[SUM_W-1] ? '1 : sum_a_c[PM_W-1:0];
    cand_b_c = sum_b_c[SUM_W-1] ? '1 : sum_b_c[PM_W-1:0];
    sel_b_c  = cand_b_c < cand_a_c;
  end
`endif

  // Ties fall to A; step counter saturates so tb_ready stays up on long frames.
  always_comb begin
    sel_pm_c       = sel_b_c ? cand_b_c : cand_a_c;
    step_cnt_nxt_c = step_cnt;
    if (bus.frame_start) begin
      step_cnt_nxt_c = '0;
    end else if (bus.in_valid && (step_cnt != CNT_MAX)) begin
      step_cnt_nxt_c = step_cnt + 7'd1;
    end
  end

  // Reset and frame start load identical initial state.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.frame_start) begin
      pm_q     <= PM_INIT;
      dec_q    <= 1'b0;
      valid_q  <= 1'b0;
      hist_q   <= '0;
      ready_q  <= 1'b0;
      step_cnt <= '0;
    end else begin
      valid_q  <= bus.in_valid;
      ready_q  <= step_cnt_nxt_c >= TB_THR;
      step_cnt <= step_cnt_nxt_c;
      if (bus.in_valid) begin
        pm_q   <= sel_pm_c;
        dec_q  <= sel_b_c;
        hist_q <= {hist_q[TB_DEPTH-2:0], sel_b_c};
      end
    end
  end

  assign bus.pm_out    = pm_q;
  assign bus.dec_bit   = dec_q;
  assign bus.out_valid = valid_q;
  assign bus.dec_hist  = hist_q;
  assign bus.tb_ready  = ready_q;
endmodule

// File: tb/tb_acs_node.sv
// Self-checking bench for acs_node: vector table plus multi-cycle sequences,
// expected outputs queued at drive time and popped one cycle later.
module tb_acs_node;
  localparam int unsigned PM_W     = 8;
  localparam int unsigned TB_DEPTH = 32;
  localparam logic [7:0]  INIT_B   = 8'd32;
  localparam logic [7:0]  INIT_Z   = 8'd0;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  acs_node_if #(.PM_W(PM_W), .TB_DEPTH(TB_DEPTH)) bus ();
  acs_node_if #(.PM_W(PM_W), .TB_DEPTH(TB_DEPTH)) busz ();

  acs_node #(.PM_W(PM_W), .TB_DEPTH(TB_DEPTH), .INIT_ZERO(0), .INIT_BIAS(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  acs_node #(.PM_W(PM_W), .TB_DEPTH(TB_DEPTH), .INIT_ZERO(1), .INIT_BIAS(32)) dut_z (
    .clk(clk), .rst_n(rst_n), .bus(busz)
  );

  assign busz.frame_start = bus.frame_start;
  assign busz.in_valid    = bus.in_valid;
  assign busz.bm_a        = bus.bm_a;
  assign busz.bm_b        = bus.bm_b;
  assign busz.pm_a        = bus.pm_a;
  assign busz.pm_b        = bus.pm_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ov;
    logic [7:0]  pm;
    logic        dec;
    logic [31:0] hist;
    logic        rdy;
    logic [7:0]  pmz;
  } exp_t;

  typedef struct {
    logic       fs;
    logic       vld;
    logic [1:0] bma;
    logic [1:0] bmb;
    logic [7:0] pma;
    logic [7:0] pmb;
    logic [7:0] epm;
    logic       edec;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[10];
  logic [7:0]  m_pm;
  logic [7:0]  m_pmz;
  logic        m_dec;
  logic [31:0] m_hist;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Drive one cycle, advance the reference state, queue its expected outputs, check after the edge.
  task automatic apply(input logic rst, input logic fs, input logic vld,
                       input logic [1:0] bma, input logic [1:0] bmb,
                       input logic [7:0] pma, input logic [7:0] pmb,
                       input logic [7:0] epm, input logic edec);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_n           = ~rst;
    bus.frame_start = fs;
    bus.in_valid    = vld;
    bus.bm_a        = bma;
    bus.bm_b        = bmb;
    bus.pm_a        = pma;
    bus.pm_b        = pmb;
    if (rst || fs) begin
      m_pm = INIT_B; m_pmz = INIT_Z; m_dec = 1'b0; m_hist = '0; m_cnt = 0; e.ov = 1'b0;
    end else if (vld) begin
      m_pm = epm; m_pmz = epm; m_dec = edec; m_hist = {m_hist[30:0], edec};
      if (m_cnt < 127) m_cnt++;
      e.ov = 1'b1;
    end else begin
      e.ov = 1'b0;
    end
    e.pm = m_pm; e.pmz = m_pmz; e.dec = m_dec; e.hist = m_hist; e.rdy = (m_cnt >= 32);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("out_valid", 32'(bus.out_valid), 32'(got.ov));
    check("pm_out",    32'(bus.pm_out),    32'(got.pm));
    check("dec_bit",   32'(bus.dec_bit),   32'(got.dec));
    check("dec_hist",  bus.dec_hist,       got.hist);
    check("tb_ready",  32'(bus.tb_ready),  32'(got.rdy));
    check("pm_out_z",  32'(busz.pm_out),   32'(got.pmz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.bm_a = '0; bus.bm_b = '0; bus.pm_a = '0; bus.pm_b = '0;
    m_pm = INIT_B; m_pmz = INIT_Z; m_dec = 1'b0; m_hist = '0; m_cnt = 0;

    //            fs    vld   bma   bmb   pma     pmb     epm     edec
    vecs[0] = '{1'b1, 1'b0, 2'd0, 2'd0, 8'd0,   8'd0,   8'd0,   1'b0};
    vecs[1] = '{1'b0, 1'b1, 2'd2, 2'd0, 8'd10,  8'd9,   8'd9,   1'b1};
    vecs[2] = '{1'b0, 1'b1, 2'd1, 2'd2, 8'd5,   8'd4,   8'd6,   1'b0};
    vecs[3] = '{1'b0, 1'b0, 2'd3, 2'd0, 8'd0,   8'd0,   8'd0,   1'b0};
`ifdef ACS_MODULO_NORM_EN
    vecs[4] = '{1'b0, 1'b1, 2'd2, 2'd0, 8'd254, 8'd3,   8'd0,   1'b0};
`else
    vecs[4] = '{1'b0, 1'b1, 2'd2, 2'd0, 8'd254, 8'd3,   8'd3,   1'b1};
`endif
    vecs[5] = '{1'b0, 1'b1, 2'd3, 2'd0, 8'd100, 8'd200, 8'd103, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 2'd0, 2'd1, 8'd0,   8'd0,   8'd0,   1'b0};
    vecs[7] = '{1'b0, 1'b1, 2'd1, 2'd0, 8'd50,  8'd50,  8'd50,  1'b1};
    vecs[8] = '{1'b1, 1'b1, 2'd0, 2'd0, 8'd1,   8'd0,   8'd0,   1'b0};
`ifdef ACS_MODULO_NORM_EN
    vecs[9] = '{1'b0, 1'b1, 2'd3, 2'd2, 8'd255, 8'd254, 8'd0,   1'b1};
`else
    vecs[9] = '{1'b0, 1'b1, 2'd3, 2'd2, 8'd255, 8'd254, 8'd255, 1'b0};
`endif

    // Reset values of both instances.
    apply(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 8'd7, 8'd7, 8'd0, 1'b0);

    foreach (vecs[i])
      apply(1'b0, vecs[i].fs, vecs[i].vld, vecs[i].bma, vecs[i].bmb,
            vecs[i].pma, vecs[i].pmb, vecs[i].epm, vecs[i].edec);

    // 32 alternating decisions starting with B; tb_ready on the 32nd output.
    apply(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) apply(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 8'd20, 8'd10, 8'd10, 1'b1);
      else            apply(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 8'd10, 8'd20, 8'd10, 1'b0);
      if (i == 30) check("tb_ready_31", 32'(bus.tb_ready), 32'd0);
    end
    check("hist_alt", bus.dec_hist, 32'hAAAAAAAA);
    check("tb_ready_32", 32'(bus.tb_ready), 32'd1);
    apply(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 8'd9, 8'd30, 8'd9, 1'b0);

    // Frame start clears history and readiness and reloads the init metric.
    apply(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    check("hist_cleared", bus.dec_hist, 32'h0);

    // Mid-frame reset, then the first step runs without a frame start.
    apply(1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 8'd40, 8'd30, 8'd30, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 8'd12, 8'd12, 8'd12, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 8'd1,  8'd2,  8'd0,  1'b0);
    apply(1'b0, 1'b0, 1'b1, 2'd3, 2'd1, 8'd60, 8'd61, 8'd62, 1'b1);

    // Reset and frame start together.
    apply(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 8'd5, 8'd5, 8'd0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
